// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder and instruction fetch front end.
// Runs a req/ack fetch from instruction memory and presents the instruction to
// decode over valid/ready. The decoder's redirect controls are sampled when the
// instruction is accepted, and they select the next PC.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a target
// whose low two bits are not zero halts the unit and raises misalign.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Jalr,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic [31:0] instr_count,
  output logic        misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        req_q, valid_q;
  logic [31:0] next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  // Redirect target selection: jalr beats branch/jump, which beat the fall-through.
  always_comb begin
    if (Jalr) begin
      next_pc = ALUResult & 32'hFFFF_FFFE;
    end else if (Branch | Jump) begin
      next_pc = pc_q + ImmExt;
    end else begin
      next_pc = pc_q + 32'd4;
    end
`ifndef FETCH_MISALIGN_TRAP_EN
    // Without the trap, targets are silently forced to word alignment.
    next_pc[1:0] = 2'b00;
`endif
  end

  // Next-state logic for the FSM and the PC, instruction and counter registers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = S_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (next_pc[1:0] != 2'b00) begin
            state_d    = S_HALT;
            misalign_d = 1'b1;
          end
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; the handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      count_q <= 32'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      req_q   <= (state_d == S_FETCH);
      valid_q <= (state_d == S_HOLD);
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_count = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign    = misalign_q;
`else
  assign misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit (default RESET_PC = 0).
// Inputs are driven and outputs checked 1 time unit after each rising edge.
// Build with FETCH_MISALIGN_TRAP_EN defined to exercise the trap variant.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Branch, Jump, Jalr;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic [31:0] instr_count;
  logic        misalign;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .op(op), .funct3(funct3),
    .pc(pc), .pc_plus4(pc_plus4),
    .Branch(Branch), .Jump(Jump), .Jalr(Jalr),
    .ImmExt(ImmExt), .ALUResult(ALUResult),
    .instr_count(instr_count), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From FETCH: ack the word immediately, then accept it with the given redirects.
  task automatic run_instr(input logic [31:0] word, input logic br, input logic jp,
                           input logic jr, input logic [31:0] imm, input logic [31:0] alu);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    check("hold_valid", instr_valid, 1'b1);
    check("hold_instr", instr, word);
    Branch = br; Jump = jp; Jalr = jr; ImmExt = imm; ALUResult = alu;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0; Branch = 1'b0; Jump = 1'b0; Jalr = 1'b0;
    ImmExt = 32'h0; ALUResult = 32'h0;
    exp_count++;
    $display("instr %h accepted, imem_addr=%h count=%0d", word, imem_addr, instr_count);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    Branch = 1'b0; Jump = 1'b0; Jalr = 1'b0; ImmExt = 32'h0; ALUResult = 32'h0;
    tick(); tick();

    // Reset state
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_count", instr_count, 32'd0);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_misalign", misalign, 1'b0);
    reset = 1'b0;
    tick();
    check("first_req", imem_req, 1'b1);

    // Straight-line fetch with same-cycle acks
    for (int i = 0; i < 4; i++) begin
      check("seq_req", imem_req, 1'b1);
      check("seq_addr", imem_addr, 32'(i * 4));
      check("seq_valid_low", instr_valid, 1'b0);
      run_instr(32'h0050_0093 + 32'(i << 20), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    check("seq_count", instr_count, 32'd4);
    check("seq_op_last", op, 7'h13);
    check("seq_pc_plus4", pc_plus4, 32'd20);

    // Memory wait states: address held while request outstanding
    for (int i = 0; i < 3; i++) begin
      check("wait_req", imem_req, 1'b1);
      check("wait_addr", imem_addr, 32'h10);
      check("wait_valid", instr_valid, 1'b0);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'h00C0_C463;
    tick();
    // Backpressure: late ack with different data and redirect noise must be ignored
    imem_rdata = 32'h1234_5678; Branch = 1'b1; ImmExt = 32'h40;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", instr_valid, 1'b1);
      check("bp_req", imem_req, 1'b0);
      check("bp_instr", instr, 32'h00C0_C463);
      check("bp_op", op, 7'h63);
      check("bp_funct3", funct3, 3'd4);
      check("bp_pc", pc, 32'h10);
      tick();
    end
    imem_ack = 1'b0; Branch = 1'b0; ImmExt = 32'h0;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0; exp_count++;
    check("bp_next_addr", imem_addr, 32'h14);
    check("bp_count", instr_count, 32'(exp_count));

    // Redirects
    run_instr(32'h0EC0_006F, 1'b0, 1'b1, 1'b0, 32'h0000_00EC, 32'h0);
    check("jump_to_100", imem_addr, 32'h100);
    run_instr(32'hFE00_0CE3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    check("branch_back", imem_addr, 32'h0F8);
    run_instr(32'h0080_006F, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    check("jump_fwd8", imem_addr, 32'h100);
    run_instr(32'h0200_006F, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    check("jump_20", imem_addr, 32'h120);
    run_instr(32'h0000_8067, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_2001);
    check("jalr", imem_addr, 32'h2000);
    run_instr(32'h0000_8067, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_3000);
    check("jalr_priority", imem_addr, 32'h3000);
    check("redir_count", instr_count, 32'(exp_count));

    // Reset during FETCH, late ack the cycle after reset
    tick();
    check("pre_rst_req", imem_req, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_0033;
    check("midrst_req", imem_req, 1'b0);
    check("midrst_pc", pc, 32'h0);
    tick();
    imem_ack = 1'b0;
    check("midrst_valid", instr_valid, 1'b0);
    check("midrst_fresh_req", imem_req, 1'b1);
    check("midrst_instr", instr, 32'h0000_0013);
    check("midrst_count", instr_count, 32'd0);
    tick();
    check("midrst_valid2", instr_valid, 1'b0);
    exp_count = 0;

    // Wrap-around of the PC
    run_instr(32'h0000_8067, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
    check("wrap_setup", imem_addr, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    run_instr(32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Misaligned target
    run_instr(32'h1000_006F, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    check("mis_setup", imem_addr, 32'h100);
    run_instr(32'h0000_0363, 1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'h0);
    check("mis_count", instr_count, 32'(exp_count));
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      check("halt_misalign", misalign, 1'b1);
      check("halt_pc", pc, 32'h106);
      check("halt_req", imem_req, 1'b0);
      check("halt_valid", instr_valid, 1'b0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("halt_rst_misalign", misalign, 1'b0);
    tick();
    check("halt_rst_req", imem_req, 1'b1);
`else
    check("mis_forced_addr", imem_addr, 32'h104);
    check("mis_flag", misalign, 1'b0);
    check("mis_req", imem_req, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential front end that drives the main decoder: holds the PC, fetches 32-bit instructions from instruction memory over a req/ack handshake and presents `op`/`funct3` with a valid/ready handshake. When the instruction is accepted, it samples the decoder's `Branch`, `Jump` and `Jalr` outputs and computes the next PC. Sits between instruction memory and the decode/execute datapath.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request, high in FETCH only.
- `imem_addr`  out  32  fetch address, equals `pc`.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instr` and `pc` are valid for decode.
- `instr_ready`  in  1  downstream accepts the instruction this cycle.
- `instr`  out  32  registered instruction.
- `op`  out  7  `instr[6:0]`.
- `funct3`  out  3  `instr[14:12]`.
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc + 4`, mod 2^32.
- `Branch`, `Jump`, `Jalr`  in  1 each  decoder redirect controls, sampled on accept.
- `ImmExt`  in  32  sign-extended immediate for the branch/jal target.
- `ALUResult`  in  32  jalr target (rs1 + imm).
- `instr_count`  out  32  number of accepted instructions; wraps.
- `misalign`  out  1  misaligned-target trap flag; tied 0 unless the trap is configured.

## Operation
- States:
  - IDLE: reset state.
  - FETCH: request outstanding.
  - HOLD: instruction presented.
  - HALT: trap; exists only with the trap configured.
- State transitions:
  - IDLE → FETCH unconditionally on the next clock.
  - FETCH: `imem_req`=1; on `imem_ack`, `instr` <= `imem_rdata` and go to HOLD.
  - HOLD: `instr_valid`=1. On `instr_ready`, `pc` <= `next_pc`, `instr_count` increments, and the state goes to FETCH.
- `next_pc` priority:
  - `Jalr`: {`ALUResult[31:1]`, 1'b0}.
  - Else `Branch | Jump`: `pc + ImmExt`.
  - Else `pc + 4`.
  - All arithmetic is 32-bit and wraps silently.
- `imem_ack` outside FETCH is ignored. `imem_rdata` is ignored unless `imem_ack` is high.
- `instr`, `pc`, `op` and `funct3` are stable for the whole HOLD state. Redirect inputs are ignored except in the accept cycle.
- Reset at any point, including mid-fetch or mid-hold, takes effect on that clock edge. The outstanding request is abandoned, and a late `imem_ack` after reset is ignored because the state is IDLE.

## Timing
- Reset values:
  - state IDLE
  - `pc`=`RESET_PC`
  - `instr`=32'h0000_0013 (nop)
  - `instr_count`=0
  - `imem_req`=0, `instr_valid`=0, `misalign`=0
- `imem_req` and `instr_valid` are decoded from the state register (Moore) and are never high together.
- `imem_addr` is held constant while `imem_req` is high.
- Fetch latency:
  - Ack can arrive in the same cycle as the request.
  - Request at cycle N with ack at N gives `instr_valid` at N+1.
  - An ack k cycles later gives `instr_valid` at N+1+k.
- Throughput: 2 cycles per instruction at minimum (FETCH, HOLD), with the next request in the cycle after accept.
- First `imem_req` is 1 cycle after `reset` deasserts.

## Configuration
- `FETCH_MISALIGN_TRAP_EN`:
  - Defined: in the accept cycle, if `next_pc[1:0]` != 0, the state goes to HALT instead of FETCH. `pc` is loaded with the faulting target, `instr_count` still increments, and `misalign` goes to 1 the next cycle. HALT is left only by `reset`; `imem_req` and `instr_valid` stay 0.
  - Undefined: `next_pc[1:0]` is forced to 2'b00, there is no HALT state, and `misalign` is tied 0.

## Test plan
- Reset and straight-line fetch:
  - Stimulus: reset, then ack every request in the same cycle with `instr_ready`=1 and no redirects.
  - Required: `imem_addr` = 0, 4, 8, 12 on successive requests. `instr_valid` pulses every other cycle. `instr_count`=4 after four accepts.
- Memory wait states and downstream backpressure:
  - Stimulus: ack 3 cycles after the request, then hold `instr_ready`=0 for 5 cycles.
  - Required: `imem_addr` stays stable while waiting. `instr`, `op`, `funct3` and `pc` stay stable during backpressure, with no new request.
- Redirects:
  - Branch: `pc`=0x100, `Branch`=1, `ImmExt`=0xFFFF_FFF8 → next `imem_addr`=0x0F8.
  - Jump: `Jump`=1, `ImmExt`=0x20 → 0x120.
  - Jalr: `Jalr`=1, `ALUResult`=0x2001 → 0x2000.
  - Priority: `Jalr`=1 with `Jump`=1 → the Jalr target is used.
- Wrap-around:
  - Stimulus: `RESET_PC`=0xFFFF_FFFC, then accept with no redirect.
  - Required: next `imem_addr`=0x0000_0000. With `instr_count` preloaded near its maximum by many accepts, the counter wraps to 0.
- Reset mid-operation:
  - Stimulus: assert `reset` during FETCH, then give `imem_ack` in the cycle after reset.
  - Required: the ack is ignored and `instr_valid` stays 0. `pc` = `RESET_PC`, and a fresh request is issued 1 cycle after `reset` deasserts.
- Misaligned target:
  - Stimulus: `Branch`=1 with `ImmExt`=0x6 at `pc`=0x100.
  - With `FETCH_MISALIGN_TRAP_EN`: HALT, `misalign`=1, `pc`=0x106, no further `imem_req`.
  - Without it: next `imem_addr`=0x104.
